// File: rtl/pass_gate_sequencer.sv
// Gate-line sequencer for a pass-transistor analog mux: at most one gate driven,
// an all-off dead time before every ON phase, single-channel dwell or round-robin scan.
module pass_gate_sequencer #(
  parameter int N_CH        = 32,
  parameter int CH_W        = $clog2(N_CH),
  parameter int DWELL_W     = 8,
  parameter int DEAD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [CH_W-1:0]    ch_sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_CH-1:0]    vg,
  output logic [CH_W-1:0]    ch_cur,
  output logic               busy,
  output logic               sample,
  output logic               done
);

  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam int CNT_W  = (DWELL_W > DEAD_W) ? DWELL_W : DEAD_W;

  localparam logic [CNT_W-1:0] LP_DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CH_W:0]    LP_N_EXT     = (CH_W + 1)'(N_CH);
  localparam logic [CH_W-1:0]  LP_CH_LAST   = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_ON} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [CH_W-1:0]      r_ch, w_ch_nxt;
  logic                 r_mode, w_mode_nxt;
  logic [DWELL_W-1:0]   r_dwell, w_dwell_nxt;
  logic                 r_stop_pend, w_stop_pend_nxt;
  logic [N_CH-1:0]      r_vg, w_vg_nxt;
  logic                 r_busy, r_sample, w_sample_nxt;
  logic                 r_done, w_done_nxt;

  logic [N_CH-1:0]      w_onehot;
  logic [CH_W-1:0]      w_sel_clamped;
  logic [CNT_W-1:0]     w_dwell_ext;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_stop_req;

  assign w_onehot      = {{(N_CH-1){1'b0}}, 1'b1} << r_ch;
  assign w_sel_clamped = ({1'b0, ch_sel} >= LP_N_EXT) ? LP_CH_LAST : ch_sel;
  assign w_dwell_ext   = CNT_W'(r_dwell);
  assign w_cnt_inc     = r_cnt + CNT_W'(1);
  assign w_stop_req    = r_stop_pend | stop;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_ch_nxt        = r_ch;
    w_mode_nxt      = r_mode;
    w_dwell_nxt     = r_dwell;
    w_stop_pend_nxt = r_stop_pend;
    w_vg_nxt        = '0;
    w_sample_nxt    = 1'b0;
    w_done_nxt      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_stop_pend_nxt = 1'b0;
        if (start) begin
          w_state_nxt = S_DEAD;
          w_cnt_nxt   = '0;
          w_mode_nxt  = mode;
          w_dwell_nxt = dwell;
          w_ch_nxt    = w_sel_clamped;
        end
      end

      S_DEAD: begin
        if (w_stop_req) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_cnt == LP_DEAD_LAST) begin
          w_state_nxt  = S_ON;
          w_cnt_nxt    = '0;
          w_vg_nxt     = w_onehot;
          w_sample_nxt = (r_dwell == '0);
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      S_ON: begin
        w_stop_pend_nxt = w_stop_req;
        if (r_cnt == w_dwell_ext) begin
          // The ON phase always runs to completion; stop only decides what follows.
          if (!r_mode || w_stop_req) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DEAD;
            w_cnt_nxt   = '0;
            w_ch_nxt    = (r_ch == LP_CH_LAST) ? '0 : r_ch + CH_W'(1);
          end
        end else begin
          w_cnt_nxt    = w_cnt_inc;
          w_vg_nxt     = w_onehot;
          w_sample_nxt = (w_cnt_inc == w_dwell_ext);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ch        <= '0;
      r_mode      <= 1'b0;
      r_dwell     <= '0;
      r_stop_pend <= 1'b0;
      r_vg        <= '0;
      r_busy      <= 1'b0;
      r_sample    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ch        <= w_ch_nxt;
      r_mode      <= w_mode_nxt;
      r_dwell     <= w_dwell_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      r_vg        <= w_vg_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_sample    <= w_sample_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign vg     = r_vg;
  assign ch_cur = r_ch;
  assign busy   = r_busy;
  assign sample = r_sample;
  assign done   = r_done;

endmodule

// File: tb/tb_pass_gate_sequencer.sv
// Scoreboard bench: stimulus pushes the expected per-cycle trace of each sequence,
// monitors pop and compare every cycle the DUT is busy or pulsing done.
module tb_pass_gate_sequencer;

  typedef struct packed {
    logic [31:0] vg;
    logic [4:0]  ch;
    logic        busy;
    logic        sample;
    logic        done;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_b = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic [4:0]  ch_sel = '0;
  logic [7:0]  dwell = '0;

  logic [31:0] a_vg;
  logic [4:0]  a_ch;
  logic        a_busy, a_sample, a_done;
  logic [19:0] b_vg;
  logic [4:0]  b_ch;
  logic        b_busy, b_sample, b_done;

  rec_t q_a[$];
  rec_t q_b[$];
  rec_t got_a, exp_a, got_b, exp_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pass_gate_sequencer #(.N_CH(32), .DWELL_W(8), .DEAD_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .ch_sel(ch_sel), .dwell(dwell), .vg(a_vg), .ch_cur(a_ch),
    .busy(a_busy), .sample(a_sample), .done(a_done)
  );

  pass_gate_sequencer #(.N_CH(20), .DWELL_W(8), .DEAD_CYCLES(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop), .mode(mode),
    .ch_sel(ch_sel), .dwell(dwell), .vg(b_vg), .ch_cur(b_ch),
    .busy(b_busy), .sample(b_sample), .done(b_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit b, input rec_t r);
    if (b) q_b.push_back(r);
    else   q_a.push_back(r);
  endtask

  task automatic push_dead(input bit b, input int ch, input int n);
    for (int i = 0; i < n; i++)
      push(b, '{vg: 32'd0, ch: 5'(ch), busy: 1'b1, sample: 1'b0, done: 1'b0});
  endtask

  task automatic push_on(input bit b, input int ch, input int dw);
    for (int i = 0; i <= dw; i++)
      push(b, '{vg: 32'd1 << ch, ch: 5'(ch), busy: 1'b1, sample: (i == dw), done: 1'b0});
  endtask

  task automatic push_done(input bit b, input int ch);
    push(b, '{vg: 32'd0, ch: 5'(ch), busy: 1'b0, sample: 1'b0, done: 1'b1});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit b, input int budget);
    int n = 0;
    while (n < budget &&
           (b ? (q_b.size() != 0 || b_busy || b_done)
              : (q_a.size() != 0 || a_busy || a_done))) begin
      tick();
      n++;
    end
    if (b) check("drain_b", {q_b.size(), b_busy}, '0);
    else   check("drain_a", {q_a.size(), a_busy}, '0);
  endtask

  always @(negedge clk) begin
    check("onehot_a", 64'($countones(a_vg) <= 1), 64'd1);
    if (a_busy || a_done) begin
      got_a = '{vg: a_vg, ch: a_ch, busy: a_busy, sample: a_sample, done: a_done};
      if (q_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_out_a: got %h expected no output", got_a);
      end else begin
        exp_a = q_a.pop_front();
        check("trace_a", got_a, exp_a);
      end
    end
  end

  always @(negedge clk) begin
    check("onehot_b", 64'($countones(b_vg) <= 1), 64'd1);
    if (b_busy || b_done) begin
      got_b = '{vg: 32'(b_vg), ch: b_ch, busy: b_busy, sample: b_sample, done: b_done};
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_out_b: got %h expected no output", got_b);
      end else begin
        exp_b = q_b.pop_front();
        check("trace_b", got_b, exp_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, sampled while rst is held.
    #11;
    check("rst_vg",   a_vg, '0);
    check("rst_ch",   a_ch, '0);
    check("rst_ctl",  {a_busy, a_sample, a_done}, '0);
    check("rst_b",    {b_vg, b_ch, b_busy, b_sample, b_done}, '0);
    #1 rst = 1'b0;
    tick();

    // Single channel 5, dwell 3: ON k+2..k+5, sample k+5, done k+6.
    mode = 1'b0; ch_sel = 5'd5; dwell = 8'd3; start = 1'b1;
    push_dead(0, 5, 2); push_on(0, 5, 3); push_done(0, 5);
    tick(); start = 1'b0;
    repeat (6) tick();
    // Start with stop in IDLE, issued in the cycle right after done.
    ch_sel = 5'd0; dwell = 8'd0; start = 1'b1; stop = 1'b1;
    push_dead(0, 0, 2); push_on(0, 0, 0); push_done(0, 0);
    tick(); start = 1'b0; stop = 1'b0;
    wait_idle(0, 50);

    // Scan from 30 with dwell 0: 30, 31, 0, 1; mid-scan input changes ignored.
    mode = 1'b1; ch_sel = 5'd30; dwell = 8'd0; start = 1'b1;
    push_dead(0, 30, 2); push_on(0, 30, 0);
    push_dead(0, 31, 2); push_on(0, 31, 0);
    push_dead(0, 0, 2);  push_on(0, 0, 0);
    push_dead(0, 1, 2);  push_on(0, 1, 0);
    push_done(0, 1);
    tick(); start = 1'b0;
    repeat (3) tick();
    start = 1'b1; ch_sel = 5'd3; mode = 1'b0; dwell = 8'd7;
    tick(); start = 1'b0;
    repeat (7) tick();
    stop = 1'b1;
    tick(); stop = 1'b0;
    wait_idle(0, 50);

    // Stop in the second ON cycle of a dwell-4 phase: phase completes, then done.
    mode = 1'b1; ch_sel = 5'd10; dwell = 8'd4; start = 1'b1;
    push_dead(0, 10, 2); push_on(0, 10, 4); push_done(0, 10);
    tick(); start = 1'b0;
    repeat (3) tick();
    stop = 1'b1;
    tick(); stop = 1'b0;
    wait_idle(0, 50);

    // Stop during DEAD before channel 3: done next edge, channel 3 never driven.
    mode = 1'b1; ch_sel = 5'd2; dwell = 8'd1; start = 1'b1;
    push_dead(0, 2, 2); push_on(0, 2, 1); push_dead(0, 3, 1); push_done(0, 3);
    tick(); start = 1'b0;
    repeat (4) tick();
    stop = 1'b1;
    tick(); stop = 1'b0;
    wait_idle(0, 50);

    // Clamp on the 20-channel instance: ch_sel 25 drives gate 19.
    mode = 1'b0; ch_sel = 5'd25; dwell = 8'd1; start_b = 1'b1;
    push_dead(1, 19, 2); push_on(1, 19, 1); push_done(1, 19);
    tick(); start_b = 1'b0;
    wait_idle(1, 50);

    // Asynchronous reset mid-ON: outputs clear before the next edge, no done.
    mode = 1'b0; ch_sel = 5'd7; dwell = 8'd5; start = 1'b1;
    push_dead(0, 7, 2);
    push(0, '{vg: 32'd1 << 7, ch: 5'd7, busy: 1'b1, sample: 1'b0, done: 1'b0});
    tick(); start = 1'b0;
    repeat (3) tick();
    check("pre_rst_vg", a_vg, 64'd1 << 7);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", {a_vg, a_busy, a_sample, a_done}, '0);
    repeat (3) tick();
    check("rst_no_pending", q_a.size(), 0);
    #2 rst = 1'b0;
    tick();

    // Restart after reset with dwell 255: 256 ON cycles on channel 31.
    mode = 1'b0; ch_sel = 5'd31; dwell = 8'd255; start = 1'b1;
    push_dead(0, 31, 2); push_on(0, 31, 255); push_done(0, 31);
    tick(); start = 1'b0;
    wait_idle(0, 400);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
